profiler_ctrl: RTL and testbench

Run controller and PC-window configurator for the writeback-stage performance profiler. It holds software-programmable start/stop PCs and NREG entry/exit PC windows behind a small register port. An IDLE/ARMED/RUN/DONE state machine sequences a profiling run from the retired-PC stream, and the block drives registered gate, clear and hit strobes to the profiler counter bank.

---
 rtl/profiler_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_profiler_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/profiler_ctrl.sv
// Profiler run controller: IDLE/ARMED/RUN/DONE sequencing from the retired-PC stream plus NREG entry/exit PC windows.
// All outputs are registered and change one edge after the qualifying PC. The config port acks one cycle after sel, so a held sel gets one access every 2 cycles.
module profiler_ctrl #(
  parameter int XLEN = 32,
  parameter int NREG = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic [XLEN-1:0] wbk_pc_i,
  input  logic            cfg_sel_i,
  input  logic            cfg_we_i,
  input  logic [7:0]      cfg_addr_i,
  input  logic [XLEN-1:0] cfg_wdata_i,
  output logic [XLEN-1:0] cfg_rdata_o,
  output logic            cfg_ready_o,
  output logic            run_o,
  output logic            clr_o,
  output logic [NREG-1:0] reg_en_o,
  output logic [NREG-1:0] reg_hit_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            clr_nxt;
  logic [XLEN-1:0] start_pc;
  logic [XLEN-1:0] stop_pc;
  logic [NREG-1:0] valid;
  logic [XLEN-1:0] entry_pc [NREG];
  logic [XLEN-1:0] exit_pc  [NREG];
  logic [NREG-1:0] en_nxt;
  logic [NREG-1:0] hit_nxt;
  logic [XLEN-1:0] rmux;

  // Config port decode; an access happens on the edge that raises ready.
  logic       access;
  logic       wr;
  logic       rd;
  logic       aligned;
  logic [5:0] widx;
  logic       ctrl_wr;
  logic       cmd_stop;
  logic       cmd_clear;
  logic       cmd_arm;

  assign access  = cfg_sel_i & ~cfg_ready_o;
  assign wr      = access & cfg_we_i;
  assign rd      = access & ~cfg_we_i;
  assign aligned = (cfg_addr_i[1:0] == 2'b00);
  assign widx    = cfg_addr_i[7:2];
  assign ctrl_wr = wr & aligned & (widx == 6'd0);

  // One write may carry several command bits: STOP beats CLEAR beats ARM.
  assign cmd_stop  = ctrl_wr & cfg_wdata_i[1];
  assign cmd_clear = ctrl_wr & ~cfg_wdata_i[1] & cfg_wdata_i[2];
  assign cmd_arm   = ctrl_wr & ~cfg_wdata_i[1] & ~cfg_wdata_i[2] & cfg_wdata_i[0];

  logic pc_ok;
  logic hit_start;
  logic hit_stop;
  logic eval;

  assign pc_ok     = ~stall_i;
  assign hit_start = pc_ok && (wbk_pc_i == start_pc);
  assign hit_stop  = pc_ok && (wbk_pc_i == stop_pc);

  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_clear) begin
          clr_nxt = 1'b1;
        end else if (cmd_arm) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (cmd_stop) begin
          state_nxt = ST_DONE;
        end else if (hit_start) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cmd_stop || hit_stop) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cmd_clear) begin
          clr_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cmd_arm) begin
          state_nxt = ST_ARMED;
        end
      end
    endcase
  end

  // Windows only move while the run continues; leaving RUN closes all and suppresses hits.
  assign eval = (state == ST_RUN) && (state_nxt == ST_RUN);

  always_comb begin
    en_nxt  = '0;
    hit_nxt = '0;
    if (eval) begin
      for (int i = 0; i < NREG; i++) begin
        if (valid[i]) begin
          if (pc_ok && (wbk_pc_i == entry_pc[i])) begin
            en_nxt[i]  = 1'b1;
            hit_nxt[i] = 1'b1;
          end else if (pc_ok && (wbk_pc_i == exit_pc[i])) begin
            en_nxt[i] = 1'b0;
          end else begin
            en_nxt[i] = reg_en_o[i];
          end
        end
      end
    end
  end

  always_comb begin
    rmux = '0;
    if (aligned) begin
      case (widx)
        6'd0:    rmux = XLEN'(state);
        6'd1:    rmux = start_pc;
        6'd2:    rmux = stop_pc;
        6'd3:    rmux = XLEN'(valid);
        default: rmux = '0;
      endcase
      for (int i = 0; i < NREG; i++) begin
        if (widx == 6'(4 + 2 * i)) rmux = entry_pc[i];
        if (widx == 6'(5 + 2 * i)) rmux = exit_pc[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_pc <= '0;
      stop_pc  <= '0;
      valid    <= '0;
      for (int i = 0; i < NREG; i++) begin
        entry_pc[i] <= '0;
        exit_pc[i]  <= '0;
      end
    end else if (wr && aligned) begin
      case (widx)
        6'd1:    start_pc <= cfg_wdata_i;
        6'd2:    stop_pc  <= cfg_wdata_i;
        6'd3:    valid    <= cfg_wdata_i[NREG-1:0];
        default: ;
      endcase
      for (int i = 0; i < NREG; i++) begin
        if (widx == 6'(4 + 2 * i)) entry_pc[i] <= cfg_wdata_i;
        if (widx == 6'(5 + 2 * i)) exit_pc[i]  <= cfg_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      run_o       <= 1'b0;
      clr_o       <= 1'b0;
      reg_en_o    <= '0;
      reg_hit_o   <= '0;
      cfg_ready_o <= 1'b0;
      cfg_rdata_o <= '0;
    end else begin
      state       <= state_nxt;
      run_o       <= (state_nxt == ST_RUN);
      clr_o       <= clr_nxt;
      reg_en_o    <= en_nxt;
      reg_hit_o   <= hit_nxt;
      cfg_ready_o <= cfg_sel_i & ~cfg_ready_o;
      cfg_rdata_o <= rd ? rmux : '0;
    end
  end

endmodule

// File: tb/tb_profiler_ctrl.sv
// Bench for profiler_ctrl: directed vector table, hand sequences, then random traffic against a transaction-level model.
module tb_profiler_ctrl;
  localparam int XLEN = 32;
  localparam int NREG = 4;
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stall = 1'b0;
  logic [XLEN-1:0] wbk_pc = '0;
  logic            cfg_sel = 1'b0;
  logic            cfg_we = 1'b0;
  logic [7:0]      cfg_addr = '0;
  logic [XLEN-1:0] cfg_wdata = '0;
  logic [XLEN-1:0] cfg_rdata;
  logic            cfg_ready;
  logic            run;
  logic            clr;
  logic [NREG-1:0] reg_en;
  logic [NREG-1:0] reg_hit;

  int errors = 0;
  int checks = 0;

  profiler_ctrl #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .wbk_pc_i(wbk_pc),
    .cfg_sel_i(cfg_sel), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata), .cfg_ready_o(cfg_ready),
    .run_o(run), .clr_o(clr), .reg_en_o(reg_en), .reg_hit_o(reg_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cfg_op(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic clr_seen);
    stall = 1'b1;
    cfg_sel = 1'b1; cfg_we = we; cfg_addr = addr; cfg_wdata = wd;
    chk("ready_idle", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    chk("ready_ack", 32'(cfg_ready), 32'd1);
    rd = cfg_rdata;
    clr_seen = clr;
    cfg_sel = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    chk("ready_drop", 32'(cfg_ready), 32'd0);
    chk("clr_one_cycle", 32'(clr), 32'd0);
  endtask

  task automatic pc_beat(input logic [31:0] pc, input logic st);
    wbk_pc = pc; stall = st;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cfg_sel = 1'b0; cfg_we = 1'b0; stall = 1'b0; wbk_pc = '0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Transaction-level model: register file as an address-keyed map, run state by spec encoding.
  int              m_state;
  logic [31:0]     m_reg [int];
  logic [NREG-1:0] m_en;
  logic [NREG-1:0] m_hit;

  function automatic logic [31:0] m_get(input int a);
    return m_reg.exists(a) ? m_reg[a] : 32'd0;
  endfunction

  function automatic bit m_mapped(input int a);
    return (a >= 4 && a <= 12) || (a >= 16 && a < 16 + 8 * NREG);
  endfunction

  function automatic void model_reset();
    m_reg.delete();
    m_state = M_IDLE; m_en = '0; m_hit = '0;
  endfunction

  function automatic logic model_write(input int a, input logic [31:0] d);
    logic c = 1'b0;
    m_hit = '0;
    if (a == 0) begin
      if (d[1]) begin
        if (m_state == M_ARMED || m_state == M_RUN) begin m_state = M_DONE; m_en = '0; end
      end else if (d[2]) begin
        if (m_state == M_IDLE) c = 1'b1;
        else if (m_state == M_DONE) begin c = 1'b1; m_state = M_IDLE; end
      end else if (d[0]) begin
        if (m_state == M_IDLE || m_state == M_DONE) m_state = M_ARMED;
      end
    end else if (m_mapped(a)) begin
      if (a == 12) begin
        m_reg[a] = d & ((32'd1 << NREG) - 1);
        m_en = m_en & d[NREG-1:0];
      end else begin
        m_reg[a] = d;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (a == 0) return 32'(m_state);
    return m_get(a);
  endfunction

  function automatic void model_pc(input logic [31:0] pc, input logic st);
    m_hit = '0;
    if (st) return;
    if (m_state == M_ARMED && pc == m_get(4)) begin
      m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (pc == m_get(8)) begin
        m_state = M_DONE; m_en = '0;
      end else begin
        for (int i = 0; i < NREG; i++) begin
          if (m_get(12) & (32'd1 << i)) begin
            if (pc == m_get(16 + 8 * i)) begin m_en[i] = 1'b1; m_hit[i] = 1'b1; end
            else if (pc == m_get(20 + 8 * i)) m_en[i] = 1'b0;
          end
        end
      end
    end
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".run"}, 32'(run), 32'(m_state == M_RUN));
    chk({tag, ".en"},  32'(reg_en), 32'(m_en));
    chk({tag, ".hit"}, 32'(reg_hit), 32'(m_hit));
    chk({tag, ".clr"}, 32'(clr), 32'd0);
  endtask

  // Directed vectors: kind 0 = cfg write, 1 = cfg read, 2 = PC beat.
  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic        exp_run;
    logic [3:0]  exp_en;
    logic [3:0]  exp_hit;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;
  vec_t tv[$];

  task automatic add(input int k, input logic [7:0] a, input logic [31:0] d, input logic s,
                     input logic r, input logic [3:0] e, input logic [3:0] h,
                     input logic [31:0] x, input string n);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d; v.stall = s; v.exp_run = r;
    v.exp_en = e; v.exp_hit = h; v.exp_rd = x; v.name = n;
    tv.push_back(v);
  endtask

  logic [31:0] rd;
  logic        cs;
  logic [2:0]  cmds [8];
  int          sel;
  int          a;
  logic [31:0] d;
  logic        st;
  logic        exp_clr;

  initial begin
    cmds = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};

    add(1, 8'h00, 0, 0, 0, 4'h0, 4'h0, 32'h0, "rd_ctrl_reset");
    add(0, 8'h04, 32'h80001000, 0, 0, 4'h0, 4'h0, 0, "wr_start");
    add(1, 8'h04, 0, 0, 0, 4'h0, 4'h0, 32'h80001000, "rd_start");
    add(1, 8'h40, 0, 0, 0, 4'h0, 4'h0, 32'h0, "rd_unmapped");
    add(0, 8'h08, 32'h80001310, 0, 0, 4'h0, 4'h0, 0, "wr_stop");
    add(0, 8'h0C, 32'h1, 0, 0, 4'h0, 4'h0, 0, "wr_valid1");
    add(0, 8'h10, 32'h80006900, 0, 0, 4'h0, 4'h0, 0, "wr_entry0");
    add(0, 8'h14, 32'h80006ae8, 0, 0, 4'h0, 4'h0, 0, "wr_exit0");
    add(0, 8'h18, 32'h80007000, 0, 0, 4'h0, 4'h0, 0, "wr_entry1");
    add(0, 8'h1C, 32'h80007000, 0, 0, 4'h0, 4'h0, 0, "wr_exit1");
    add(0, 8'h00, 32'h1, 0, 0, 4'h0, 4'h0, 0, "arm");
    add(1, 8'h00, 0, 0, 0, 4'h0, 4'h0, 32'h1, "rd_armed");
    add(2, 0, 32'h80000000, 0, 0, 4'h0, 4'h0, 0, "pc_pre");
    add(2, 0, 32'h80001000, 0, 1, 4'h0, 4'h0, 0, "pc_start");
    add(2, 0, 32'h80006900, 0, 1, 4'h1, 4'h1, 0, "pc_entry0");
    add(2, 0, 32'h80006904, 0, 1, 4'h1, 4'h0, 0, "pc_inside0");
    add(2, 0, 32'h80006ae8, 0, 1, 4'h0, 4'h0, 0, "pc_exit0");
    add(2, 0, 32'h80006900, 1, 1, 4'h0, 4'h0, 0, "pc_entry_stall_a");
    add(2, 0, 32'h80006900, 1, 1, 4'h0, 4'h0, 0, "pc_entry_stall_b");
    add(2, 0, 32'h80006900, 0, 1, 4'h1, 4'h1, 0, "pc_entry_unstall");
    add(2, 0, 32'h80006900, 0, 1, 4'h1, 4'h1, 0, "pc_reentry");
    add(0, 8'h0C, 32'h3, 0, 1, 4'h1, 4'h0, 0, "wr_valid3_run");
    add(2, 0, 32'h80007000, 0, 1, 4'h3, 4'h2, 0, "pc_entry_eq_exit");
    add(2, 0, 32'h80006ae8, 0, 1, 4'h2, 4'h0, 0, "pc_exit0_w1_open");
    add(2, 0, 32'h80006900, 0, 1, 4'h3, 4'h1, 0, "pc_entry0_again");
    add(2, 0, 32'h80001310, 0, 0, 4'h0, 4'h0, 0, "pc_stop_open");
    add(1, 8'h00, 0, 0, 0, 4'h0, 4'h0, 32'h3, "rd_done");

    do_reset();
    chk("rst.run", 32'(run), 0);
    chk("rst.clr", 32'(clr), 0);
    chk("rst.en", 32'(reg_en), 0);
    chk("rst.hit", 32'(reg_hit), 0);
    chk("rst.ready", 32'(cfg_ready), 0);
    chk("rst.rdata", cfg_rdata, 0);

    for (int k = 0; k < tv.size(); k++) begin
      if (tv[k].kind == 1) begin
        cfg_op(1'b0, tv[k].addr, 32'h0, rd, cs);
        chk(tv[k].name, rd, tv[k].exp_rd);
      end else begin
        if (tv[k].kind == 0) cfg_op(1'b1, tv[k].addr, tv[k].data, rd, cs);
        else pc_beat(tv[k].data, tv[k].stall);
        chk({tv[k].name, ".run"}, 32'(run), 32'(tv[k].exp_run));
        chk({tv[k].name, ".en"},  32'(reg_en), 32'(tv[k].exp_en));
        chk({tv[k].name, ".hit"}, 32'(reg_hit), 32'(tv[k].exp_hit));
      end
    end

    // Command sequencing, clear behaviour and stall hold.
    do_reset();
    cfg_op(1'b1, 8'h04, 32'h80002000, rd, cs);
    cfg_op(1'b1, 8'h00, 32'h1, rd, cs);
    cfg_op(1'b1, 8'h00, 32'h2, rd, cs);
    chk("stop_armed.run", 32'(run), 0);
    cfg_op(1'b0, 8'h00, 0, rd, cs);
    chk("stop_armed.state", rd, 3);
    cfg_op(1'b1, 8'h00, 32'h4, rd, cs);
    chk("clear_done.clr", 32'(cs), 1);
    cfg_op(1'b0, 8'h00, 0, rd, cs);
    chk("clear_done.state", rd, 0);
    cfg_op(1'b1, 8'h00, 32'h5, rd, cs);
    chk("clear_arm_idle.clr", 32'(cs), 1);
    cfg_op(1'b0, 8'h00, 0, rd, cs);
    chk("clear_arm_idle.state", rd, 0);
    cfg_op(1'b1, 8'h00, 32'h1, rd, cs);
    for (int k = 0; k < 3; k++) begin
      pc_beat(32'h80002000, 1'b1);
      chk("stall_hold.run", 32'(run), 0);
    end
    pc_beat(32'h80002000, 1'b0);
    chk("stall_release.run", 32'(run), 1);
    pc_beat(32'h80002000, 1'b0);
    chk("stall_once.run", 32'(run), 1);
    cfg_op(1'b1, 8'h00, 32'h4, rd, cs);
    chk("clear_run.clr", 32'(cs), 0);
    chk("clear_run.run", 32'(run), 1);
    cfg_op(1'b1, 8'h00, 32'h7, rd, cs);
    chk("cmd7_run.run", 32'(run), 0);
    cfg_op(1'b0, 8'h00, 0, rd, cs);
    chk("cmd7_run.state", rd, 3);

    // Asynchronous reset with all windows open.
    do_reset();
    cfg_op(1'b1, 8'h04, 32'h80002000, rd, cs);
    cfg_op(1'b1, 8'h0C, 32'hF, rd, cs);
    for (int i = 0; i < NREG; i++) cfg_op(1'b1, 8'(16 + 8 * i), 32'h80003000 + 32'(4 * i), rd, cs);
    cfg_op(1'b1, 8'h00, 32'h1, rd, cs);
    pc_beat(32'h80002000, 1'b0);
    for (int i = 0; i < NREG; i++) pc_beat(32'h80003000 + 32'(4 * i), 1'b0);
    chk("all_open.en", 32'(reg_en), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.run", 32'(run), 0);
    chk("arst.en", 32'(reg_en), 0);
    chk("arst.hit", 32'(reg_hit), 0);
    chk("arst.clr", 32'(clr), 0);
    chk("arst.ready", 32'(cfg_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_op(1'b0, 8'h04, 0, rd, cs);  chk("arst.start", rd, 0);
    cfg_op(1'b0, 8'h0C, 0, rd, cs);  chk("arst.valid", rd, 0);
    cfg_op(1'b0, 8'h10, 0, rd, cs);  chk("arst.entry0", rd, 0);
    cfg_op(1'b0, 8'h00, 0, rd, cs);  chk("arst.state", rd, 0);

    // Random traffic against the model.
    do_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 12) begin
        d = 32'(cmds[$urandom_range(0, 7)]);
        exp_clr = model_write(0, d);
        cfg_op(1'b1, 8'h00, d, rd, cs);
        chk("rnd_ctrl.clr", 32'(cs), 32'(exp_clr));
        chk_model("rnd_ctrl");
      end else if (sel < 30) begin
        a = 4 * int'($urandom_range(1, 19));
        d = (a == 12) ? $urandom : 32'h80000000 + 32'(4 * $urandom_range(0, 7));
        exp_clr = model_write(a, d);
        cfg_op(1'b1, 8'(a), d, rd, cs);
        chk_model("rnd_wr");
      end else if (sel < 40) begin
        a = 4 * int'($urandom_range(0, 19));
        cfg_op(1'b0, 8'(a), 0, rd, cs);
        chk("rnd_rd", rd, model_read(a));
      end else begin
        d = 32'h80000000 + 32'(4 * $urandom_range(0, 7));
        st = ($urandom_range(0, 3) == 0);
        model_pc(d, st);
        pc_beat(d, st);
        chk_model("rnd_pc");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
